// File: rtl/ysyx_25020047_sram_if.sv
// ysyx_25020047_sram_if
// AXI4-Lite bundle between the LSU (master) and the SRAM responder (slave).
//   AR: araddr, arvalid / arready
//   R : rdata, rresp, rvalid / rready
//   AW: awaddr, awvalid / awready
//   W : wdata, wstrb, wvalid / wready
//   B : bresp, bvalid / bready
interface ysyx_25020047_sram_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/ysyx_25020047_sram.sv
// ysyx_25020047_sram
// AXI4-Lite memory responder: word-addressed array behind independent read and
// write state machines, each adding a fixed response latency of LAT cycles.
// Ports:
//   clock - rising-edge clock
//   reset - asynchronous, active-high
//   axi   - slave side of ysyx_25020047_sram_if (AR/R/AW/W/B channels)
// Optional feature: define YSYX_SRAM_RAND_DELAY_EN to add 0-7 pseudo-random
// extra wait cycles per transaction from an 8-bit LFSR.
module ysyx_25020047_sram #(
  parameter logic [31:0] BASE  = 32'h8000_0000,
  parameter int          DEPTH = 1024,
  parameter int          LAT   = 1
) (
  input logic                  clock,
  input logic                  reset,
  ysyx_25020047_sram_if.slave  axi
);

  localparam int          IW          = $clog2(DEPTH);
  localparam logic [31:0] SPAN        = 32'(DEPTH * 4);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

  logic [31:0] mem [DEPTH];

  // Wait-count loaded at each transaction start.
  logic [4:0] delay;

`ifdef YSYX_SRAM_RAND_DELAY_EN
  // Fibonacci LFSR, x^8+x^6+x^5+x^4+1, free-running.
  logic [7:0] lfsr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) lfsr <= 8'hA5;
    else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign delay = 5'(LAT) + 5'(lfsr[2:0]);
`else
  assign delay = 5'(LAT);
`endif

  // ---------------------------------------------------------------- read ---
  r_state_t    r_state, r_next;
  logic [4:0]  r_cnt;
  logic [31:0] ar_addr_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic [31:0] r_off;
  logic        r_in_range;
  logic [IW-1:0] r_idx;

  assign r_off      = ar_addr_q - BASE;
  assign r_in_range = r_off < SPAN;
  assign r_idx      = r_off[IW+1:2];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= R_IDLE;
    else       r_state <= r_next;
  end

  // NOTE: next-state defaults to the current state before the case so no
  // path leaves r_next unassigned, which would infer a latch.
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (axi.arvalid)  r_next = R_WAIT;
      R_WAIT:  if (r_cnt == '0)  r_next = R_RESP;
      R_RESP:  if (axi.rready)   r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      ar_addr_q <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: if (axi.arvalid) begin
          ar_addr_q <= axi.araddr;
          r_cnt     <= delay;
        end
        R_WAIT: if (r_cnt == '0) begin
          // Same-edge write commit is not visible here: the array still
          // holds the old word when this sample is taken.
          rdata_q <= r_in_range ? mem[r_idx] : '0;
          rresp_q <= r_in_range ? RESP_OKAY : RESP_SLVERR;
        end else begin
          r_cnt <= r_cnt - 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign axi.arready = (r_state == R_IDLE);
  assign axi.rvalid  = (r_state == R_RESP);
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = rresp_q;

  // --------------------------------------------------------------- write ---
  w_state_t    w_state, w_next;
  logic [4:0]  w_cnt;
  logic        aw_got, w_got;
  logic [31:0] aw_addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [1:0]  bresp_q;
  logic        aw_open, w_open, aw_fire, w_fire, w_start, w_commit;
  logic [31:0] w_off;
  logic        w_in_range;
  logic [IW-1:0] w_idx;

  assign w_off      = aw_addr_q - BASE;
  assign w_in_range = w_off < SPAN;
  assign w_idx      = w_off[IW+1:2];

  // AW and W each stay open in W_IDLE until captured once.
  assign aw_open  = (w_state == W_IDLE) && !aw_got;
  assign w_open   = (w_state == W_IDLE) && !w_got;
  assign aw_fire  = aw_open && axi.awvalid;
  assign w_fire   = w_open && axi.wvalid;
  assign w_start  = (aw_got || aw_fire) && (w_got || w_fire);
  assign w_commit = (w_state == W_WAIT) && (w_cnt == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) w_state <= W_IDLE;
    else       w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (w_start)     w_next = W_WAIT;
      W_WAIT:  if (w_cnt == '0) w_next = W_RESP;
      W_RESP:  if (axi.bready)  w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      w_cnt     <= '0;
      aw_got    <= 1'b0;
      w_got     <= 1'b0;
      aw_addr_q <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_fire) begin
            aw_addr_q <= axi.awaddr;
            aw_got    <= 1'b1;
          end
          if (w_fire) begin
            wdata_q <= axi.wdata;
            wstrb_q <= axi.wstrb;
            w_got   <= 1'b1;
          end
          // Later assignments win: flags are cleared for the next transaction.
          if (w_start) begin
            w_cnt  <= delay;
            aw_got <= 1'b0;
            w_got  <= 1'b0;
          end
        end
        W_WAIT: begin
          if (w_cnt == '0) bresp_q <= w_in_range ? RESP_OKAY : RESP_SLVERR;
          else             w_cnt   <= w_cnt - 5'd1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the array has no reset; contents survive reset like real SRAM, and
  // keeping reset off this block lets it map onto memory macros.
  always_ff @(posedge clock) begin
    if (w_commit && w_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[b]) mem[w_idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign axi.awready = aw_open;
  assign axi.wready  = w_open;
  assign axi.bvalid  = (w_state == W_RESP);
  assign axi.bresp   = bresp_q;

endmodule

// File: tb/tb_ysyx_25020047_sram.sv
// tb_ysyx_25020047_sram
// Self-checking bench for ysyx_25020047_sram: directed scenarios plus random
// reads/writes against a word-array model; a negedge monitor checks every
// R/B response cycle against expectation queues.
module tb_ysyx_25020047_sram;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          LAT  = 1;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;

  logic clock;
  logic reset;
  int   cyc;
  int   checks;
  int   failures;

  logic [31:0] model_mem [1024];
  rexp_t       exp_r [$];
  logic [1:0]  exp_b [$];
  logic [31:0] last_rdata;
  logic [1:0]  last_rresp;
  logic [1:0]  last_bresp;

  ysyx_25020047_sram_if axi ();

  ysyx_25020047_sram #(.BASE(BASE), .DEPTH(1024), .LAT(LAT)) dut (
    .clock (clock),
    .reset (reset),
    .axi   (axi)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic in_range(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    return off < 32'd4096;
  endfunction

  function automatic int widx(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    return int'(off[11:2]);
  endfunction

  function automatic rexp_t expected_read(input logic [31:0] addr);
    rexp_t e;
    if (in_range(addr)) begin
      e.data = model_mem[widx(addr)];
      e.resp = 2'b00;
    end else begin
      e.data = 32'h0;
      e.resp = 2'b10;
    end
    return e;
  endfunction

  // Response monitor: every cycle a response is offered it must match the
  // oldest expectation, and stay put until the handshake consumes it.
  always @(negedge clock) begin
    if (!reset) begin
      if (axi.rvalid) begin
        if (exp_r.size() == 0) begin
          check("r_unexpected", 32'(axi.rvalid), 32'd0);
        end else begin
          check("rdata", axi.rdata, exp_r[0].data);
          check("rresp", 32'(axi.rresp), 32'(exp_r[0].resp));
          check("arready_in_resp", 32'(axi.arready), 32'd0);
          if (axi.rready) begin
            last_rdata = axi.rdata;
            last_rresp = axi.rresp;
            void'(exp_r.pop_front());
          end
        end
      end
      if (axi.bvalid) begin
        if (exp_b.size() == 0) begin
          check("b_unexpected", 32'(axi.bvalid), 32'd0);
        end else begin
          check("bresp", 32'(axi.bresp), 32'(exp_b[0]));
          check("awready_in_resp", 32'(axi.awready), 32'd0);
          check("wready_in_resp", 32'(axi.wready), 32'd0);
          if (axi.bready) begin
            last_bresp = axi.bresp;
            void'(exp_b.pop_front());
          end
        end
      end
    end
  end

  task automatic do_read(input logic [31:0] addr, input int hold);
    bit ok;
    int start;
    @(posedge clock); #1;
    axi.araddr  = addr;
    axi.arvalid = 1'b1;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (axi.arready) begin ok = 1; break; end
    end
    if (!ok) begin
      check("ar_timeout", 32'd0, 32'd1);
      axi.arvalid = 1'b0;
      return;
    end
    exp_r.push_back(expected_read(addr));
    @(posedge clock); #1;
    start = cyc;
    axi.arvalid = 1'b0;
    while (!axi.rvalid && (cyc - start) < 60) begin
      @(posedge clock); #1;
    end
    check("r_latency", 32'(cyc - start), 32'(LAT + 1));
    repeat (hold) begin @(posedge clock); #1; end
    axi.rready = 1'b1;
    @(posedge clock); #1;
    axi.rready = 1'b0;
    check("rvalid_after_hs", 32'(axi.rvalid), 32'd0);
    check("arready_after_hs", 32'(axi.arready), 32'd1);
  endtask

  // lead > 0: AW leads W by lead cycles; lead < 0: W leads AW.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int lead, input int hold);
    bit aw_ok, w_ok;
    int aw_edge, w_edge, last;
    int aw_wait, w_wait;
    aw_wait = (lead < 0) ? -lead : 0;
    w_wait  = (lead > 0) ? lead : 0;
    aw_ok = 0;
    w_ok  = 0;
    aw_edge = 0;
    w_edge  = 0;
    exp_b.push_back(in_range(addr) ? 2'b00 : 2'b10);
    @(posedge clock); #1;
    fork
      begin
        repeat (aw_wait) begin @(posedge clock); #1; end
        axi.awaddr  = addr;
        axi.awvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
          @(negedge clock);
          if (axi.awready) begin aw_ok = 1; break; end
        end
        if (aw_ok) begin @(posedge clock); #1; aw_edge = cyc; end
        axi.awvalid = 1'b0;
        if (aw_ok && lead > 0) begin
          check("aw_closed", 32'(axi.awready), 32'd0);
          check("w_still_open", 32'(axi.wready), 32'd1);
        end
      end
      begin
        repeat (w_wait) begin @(posedge clock); #1; end
        axi.wdata  = data;
        axi.wstrb  = strb;
        axi.wvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
          @(negedge clock);
          if (axi.wready) begin w_ok = 1; break; end
        end
        if (w_ok) begin @(posedge clock); #1; w_edge = cyc; end
        axi.wvalid = 1'b0;
        if (w_ok && lead < 0) begin
          check("w_closed", 32'(axi.wready), 32'd0);
          check("aw_still_open", 32'(axi.awready), 32'd1);
        end
      end
    join
    if (!(aw_ok && w_ok)) begin
      check("aw_w_timeout", 32'd0, 32'd1);
      return;
    end
    last = (aw_edge > w_edge) ? aw_edge : w_edge;
    while (!axi.bvalid && (cyc - last) < 60) begin
      @(posedge clock); #1;
    end
    check("b_latency", 32'(cyc - last), 32'(LAT + 1));
    if (in_range(addr)) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) model_mem[widx(addr)][8*b +: 8] = data[8*b +: 8];
    end
    repeat (hold) begin @(posedge clock); #1; end
    axi.bready = 1'b1;
    @(posedge clock); #1;
    axi.bready = 1'b0;
    check("bvalid_after_hs", 32'(axi.bvalid), 32'd0);
    check("awready_after_hs", 32'(axi.awready), 32'd1);
    check("wready_after_hs", 32'(axi.wready), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_arready"}, 32'(axi.arready), 32'd1);
    check({tag, "_awready"}, 32'(axi.awready), 32'd1);
    check({tag, "_wready"},  32'(axi.wready),  32'd1);
    check({tag, "_rvalid"},  32'(axi.rvalid),  32'd0);
    check({tag, "_bvalid"},  32'(axi.bvalid),  32'd0);
    check({tag, "_rdata"},   axi.rdata,        32'd0);
    check({tag, "_rresp"},   32'(axi.rresp),   32'd0);
    check({tag, "_bresp"},   32'(axi.bresp),   32'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return BASE - 32'(4 * $urandom_range(1, 100));
    if (r == 1) return BASE + 32'h1000 + 32'(4 * $urandom_range(0, 100));
    return BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
  endfunction

  initial begin
    checks      = 0;
    failures    = 0;
    last_rdata  = '0;
    last_rresp  = '0;
    last_bresp  = '0;
    reset       = 1'b1;
    axi.araddr  = '0;
    axi.arvalid = 1'b0;
    axi.rready  = 1'b0;
    axi.awaddr  = '0;
    axi.awvalid = 1'b0;
    axi.wdata   = '0;
    axi.wstrb   = '0;
    axi.wvalid  = 1'b0;
    axi.bready  = 1'b0;

    #3;
    check_reset_values("rst");
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Preload the 16-word window used by the random phase.
    for (int i = 0; i < 16; i++)
      do_write(BASE + 32'(4 * i), $urandom, 4'hF, 0, 0);

    // Full-word write/read.
    do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0);
    check("full_bresp", 32'(last_bresp), 32'd0);
    do_read(32'h8000_0010, 0);
    check("full_rdata", last_rdata, 32'hDEAD_BEEF);

    // Byte store into lane 2.
    do_write(32'h8000_0010, 32'h1122_3344, 4'hF, 0, 1);
    do_write(32'h8000_0012, 32'h00AB_0000, 4'b0100, 0, 0);
    check("model_pin", model_mem[4], 32'h11AB_3344);
    do_read(32'h8000_0010, 0);
    check("byte_rdata", last_rdata, 32'h11AB_3344);

    // Decoupled AW/W in both orders, and an all-zero strobe.
    do_write(32'h8000_0020, 32'h5555_AAAA, 4'hF, 3, 0);
    do_read(32'h8000_0020, 0);
    check("decoupled_rdata", last_rdata, 32'h5555_AAAA);
    do_write(32'h8000_0024, 32'h0F0F_0F0F, 4'hF, -2, 2);
    do_write(32'h8000_0024, 32'hFFFF_FFFF, 4'h0, 0, 0);
    check("nostrb_bresp", 32'(last_bresp), 32'd0);
    do_read(32'h8000_0024, 0);
    check("nostrb_rdata", last_rdata, 32'h0F0F_0F0F);

    // Out of range.
    do_read(32'h7FFF_FFFC, 0);
    check("oor_rdata", last_rdata, 32'h0);
    check("oor_rresp", 32'(last_rresp), 32'd2);
    do_write(32'h8000_1000, 32'hCAFE_F00D, 4'hF, 0, 0);
    check("oor_bresp", 32'(last_bresp), 32'd2);
    do_read(BASE, 0);

    // Backpressure: monitor checks stability while rready is low.
    do_read(32'h8000_0020, 5);
    do_read(32'h8000_0024, 0);

    // Same-edge read and write commits to one word: read sees old data.
    fork
      do_write(32'h8000_0030, 32'h1234_5678, 4'hF, 0, 0);
      do_read(32'h8000_0030, 0);
    join
    do_read(32'h8000_0030, 0);
    check("after_collide", last_rdata, 32'h1234_5678);

    // Reset while the read is waiting.
    @(posedge clock); #1;
    axi.araddr  = 32'h8000_0010;
    axi.arvalid = 1'b1;
    @(negedge clock);
    check("mid_ar_ready", 32'(axi.arready), 32'd1);
    @(posedge clock); #1;
    axi.arvalid = 1'b0;
    #2 reset = 1'b1;
    #1 check_reset_values("midrst");
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    repeat (4) begin
      @(posedge clock); #1;
      check("dropped_rvalid", 32'(axi.rvalid), 32'd0);
    end
    do_read(32'h8000_0010, 1);

    // Random traffic.
    for (int n = 0; n < 90; n++) begin
      logic [31:0] a;
      a = rand_addr();
      if (n % 10 == 9) begin
        fork
          do_write(a, $urandom, 4'($urandom), 0, 0);
          do_read(a, 0);
        join
      end else if ($urandom_range(0, 1) == 0) begin
        do_write(a, $urandom, 4'($urandom), $urandom_range(0, 6) - 3, $urandom_range(0, 2));
      end else begin
        do_read(a, $urandom_range(0, 3));
      end
    end

    repeat (3) @(posedge clock);
    check("r_queue_drained", 32'(exp_r.size()), 32'd0);
    check("b_queue_drained", 32'(exp_b.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
